memory_bus_unit: RTL

MEMORY_BUS_UNIT -- requirements
Module: memory_bus_unit

---
 rtl/memory_bus_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/memory_bus_unit.sv
// memory_bus_unit
//   Bridges single-word read/write requests from the instruction sequencer
//   onto an asynchronous-style external memory bus with active-low strobes.
//   Each transaction runs IDLE -> SETUP -> STROBE -> HOLD -> IDLE. STROBE
//   lasts at least WAIT_CYCLES+1 cycles, is stretched by i_bus_wait, and is
//   aborted after TIMEOUT cycles.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_mem_rd, i_mem_wr        request strobes (exactly one may be high)
//   i_addr, i_wdata           address / write data, captured at accept
//   o_rdata, o_rdata_valid    last read word, pulse when it is refreshed
//   o_done, o_busy, o_err     completion pulse, in-progress flag, error pulse
//   o_bus_addr, o_bus_wdata   external address / write data
//   o_bus_cs_n/oe_n/we_n      external active-low strobes
//   i_bus_rdata, i_bus_wait   external read data, wait request
module memory_bus_unit #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_rd,
  input  logic        i_mem_wr,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_wdata,
  output logic [15:0] o_rdata,
  output logic        o_rdata_valid,
  output logic        o_done,
  output logic        o_busy,
  output logic        o_err,
  output logic [15:0] o_bus_addr,
  output logic [15:0] o_bus_wdata,
  output logic        o_bus_cs_n,
  output logic        o_bus_oe_n,
  output logic        o_bus_we_n,
  input  logic [15:0] i_bus_rdata,
  input  logic        i_bus_wait
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  // Last STROBE cycle allowed before abort: the counter holds the number of
  // STROBE cycles already completed, so cycle number TIMEOUT sees TIMEOUT-1.
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [15:0] addr_reg;
  logic [15:0] wdata_reg;
  logic [15:0] rdata_reg;
  logic        dir_wr_reg;
  logic [3:0]  wait_cnt_reg;
  logic [7:0]  to_cnt_reg;
  logic        timeout_reg;
  logic        illegal_reg;

  logic        req_single;
  logic        req_both;
  logic        strobe_exit;
  logic        strobe_abort;

  assign req_single   = i_mem_rd ^ i_mem_wr;
  assign req_both     = i_mem_rd & i_mem_wr;
  assign strobe_exit  = (wait_cnt_reg == 4'd0) && !i_bus_wait;
  // A successful exit takes priority over an abort in the same cycle.
  assign strobe_abort = !strobe_exit && (to_cnt_reg == TO_LAST);

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (req_single) state_next = SETUP;
      SETUP:  state_next = STROBE;
      STROBE: if (strobe_exit || strobe_abort) state_next = HOLD;
      HOLD:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      addr_reg     <= 16'h0000;
      wdata_reg    <= 16'h0000;
      rdata_reg    <= 16'h0000;
      dir_wr_reg   <= 1'b0;
      wait_cnt_reg <= 4'd0;
      to_cnt_reg   <= 8'd0;
      timeout_reg  <= 1'b0;
      illegal_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      // Conflicting request is reported one cycle later and otherwise dropped.
      illegal_reg <= (state_reg == IDLE) && req_both;
      case (state_reg)
        IDLE: begin
          if (req_single) begin
            addr_reg    <= i_addr;
            wdata_reg   <= i_wdata;
            dir_wr_reg  <= i_mem_wr;
            timeout_reg <= 1'b0;
          end
        end
        SETUP: begin
          wait_cnt_reg <= WAIT_INIT;
          to_cnt_reg   <= 8'd0;
        end
        STROBE: begin
          if (wait_cnt_reg != 4'd0) wait_cnt_reg <= wait_cnt_reg - 4'd1;
          to_cnt_reg <= to_cnt_reg + 8'd1;
          if (strobe_exit && !dir_wr_reg) rdata_reg <= i_bus_rdata;
          if (strobe_abort) timeout_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state so reset forces them inactive immediately.
  always_comb begin
    o_bus_cs_n    = 1'b1;
    o_bus_oe_n    = 1'b1;
    o_bus_we_n    = 1'b1;
    o_done        = 1'b0;
    o_rdata_valid = 1'b0;
    o_err         = illegal_reg;
    case (state_reg)
      SETUP: o_bus_cs_n = 1'b0;
      STROBE: begin
        o_bus_cs_n = 1'b0;
        o_bus_oe_n = dir_wr_reg;
        o_bus_we_n = !dir_wr_reg;
      end
      HOLD: begin
        o_bus_cs_n    = 1'b0;
        o_done        = 1'b1;
        o_rdata_valid = !dir_wr_reg && !timeout_reg;
        o_err         = illegal_reg | timeout_reg;
      end
      default: ;
    endcase
  end

  assign o_busy      = (state_reg != IDLE);
  assign o_rdata     = rdata_reg;
  assign o_bus_addr  = addr_reg;
  assign o_bus_wdata = wdata_reg;

endmodule
